mf_feeder: RTL and testbench
============================

MF_FEEDER -- requirements
Module: mf_feeder

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter DATA_W, default 6, SHALL set the word width carried to the main FIFO.
REQ-003 Parameter DEPTH, default 4, SHALL set the skid-buffer depth; it SHALL be a power of two and at least 2.
REQ-004 Parameter PAUSE_TIMEOUT, default 16, SHALL set the consecutive Pausa_MF cycles, with data pending, that raise an error.
REQ-005 Port clk, input, 1 bit: the single rising-edge clock.
REQ-006 Port reset, input, 1 bit: synchronous active-high reset.
REQ-007 Port init, input, 1 bit: reinitialise request; flushes the block while high.
REQ-008 Port in_valid, input, 1 bit: the source offers a word.
REQ-009 Port in_data, input, DATA_W bits: the offered word.
REQ-010 Port in_ready, output, 1 bit: the block accepts the word this cycle.
REQ-011 Port Pausa_MF, input, 1 bit: the main FIFO almost-full pause.
REQ-012 Port push, output, 1 bit: the write strobe into the main FIFO.
REQ-013 Port data_in_principal, output, DATA_W bits: the word written into the main FIFO.
REQ-014 Port active_out, idle_out and error_out, outputs, 1 bit each: state flags.
REQ-015 Port pushed_cnt, output, 8 bits: count of words pushed, wrapping at 255.

Function
REQ-016 The FSM SHALL have the states RESET, INIT, IDLE, ACTIVE, PAUSED and ERROR.
REQ-017 The FSM SHALL move RESET->INIT on the first clock after reset deasserts.
REQ-018 From any non-RESET state, init=1 SHALL force INIT on the next edge.
REQ-019 INIT SHALL move to IDLE on the first edge with init=0.
REQ-020 IDLE SHALL move to ACTIVE when the buffer is non-empty.
REQ-021 ACTIVE SHALL move to PAUSED when Pausa_MF=1 and the buffer is non-empty.
REQ-022 ACTIVE SHALL move to IDLE when the buffer becomes empty.
REQ-023 PAUSED SHALL return to ACTIVE when Pausa_MF=0.
REQ-024 PAUSED SHALL move to ERROR when the pause counter reaches PAUSE_TIMEOUT.
REQ-025 ERROR SHALL be sticky and left only through reset or init.
REQ-026 in_ready SHALL equal !full and state ∈ {IDLE, ACTIVE, PAUSED}; it SHALL be 0 in RESET, INIT and ERROR.
REQ-027 A word SHALL be accepted exactly when in_valid and in_ready are both 1.
REQ-028 push SHALL equal state==ACTIVE and !empty and !Pausa_MF, computed combinationally from the registered state and the live Pausa_MF.
REQ-029 data_in_principal SHALL present the buffer head at all times; it SHALL be 0 when the buffer is empty.
REQ-030 Latency: a word accepted at edge N SHALL be pushable no earlier than the cycle following edge N+1; there SHALL be no input-to-output bypass.
REQ-031 Words SHALL be pushed in acceptance order, with no loss and no duplication.
REQ-032 When the buffer is full, in_ready SHALL be 0 even if a push occurs that cycle; there SHALL be no same-cycle refill.
REQ-033 When the buffer is empty and a write occurs, the word SHALL NOT be pushed in the same cycle.
REQ-034 Read and write pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from a (log2(DEPTH)+1)-bit occupancy count.
REQ-035 The pause counter SHALL increment each cycle in PAUSED, clear on leaving PAUSED, and saturate at PAUSE_TIMEOUT.
REQ-036 pushed_cnt SHALL increment by 1 on each push, wrap 255->0, and clear in INIT.
REQ-037 active_out SHALL be 1 in ACTIVE or PAUSED; idle_out SHALL be 1 in IDLE; error_out SHALL be 1 in ERROR; all three SHALL be 0 otherwise.
REQ-038 When init rises mid-transfer, the buffer SHALL flush on the next edge, with no push while init=1; buffered words are discarded.

Reset
REQ-039 On reset=1 at an edge: state=RESET, buffer empty, pointers/occupancy/pause counter/pushed_cnt=0.
REQ-040 While in RESET: in_ready=0, push=0, data_in_principal=0, active_out=idle_out=error_out=0.
REQ-041 Reset SHALL take priority over init and all other inputs.

Structure
REQ-042 Package pcie_feeder_pkg SHALL hold the FSM state encoding (3 bits, RESET=0), the DATA_W default and the counter widths.
REQ-043 The buffer SHALL be one sub-module, feeder_fifo (synchronous, DEPTH×DATA_W, with full/empty), instantiated once; the FSM and counters SHALL live in mf_feeder.

Verification
REQ-044 Reset then init pulse, then 3 words 0x15, 0x2A, 0x3F with Pausa_MF=0 -> push on 3 consecutive cycles with values 0x15, 0x2A, 0x3F; pushed_cnt=3; idle_out=1 afterwards.
REQ-045 Pausa_MF=1 while 5 words are offered -> 4 accepted, in_ready=0 on the 5th, push=0; release Pausa_MF -> 4 pushes in order, then the 5th word.
REQ-046 Pausa_MF held 16 cycles with the buffer non-empty -> error_out=1 on the next cycle and in_ready=0; init pulse -> idle_out=1, error_out=0, pushed_cnt=0.
REQ-047 Continuous stream of 300 words with no pause -> pushed_cnt wraps to 44; the scoreboard matches every word in order.
REQ-048 init asserted with 3 words buffered -> zero pushes during init, buffer empty, next accepted word 0x01 is the first pushed.
REQ-049 Random in_valid and Pausa_MF toggling for 2000 cycles -> no push while Pausa_MF=1, no loss or reordering, occupancy never exceeds 4.

Source files
------------

// File: rtl/pcie_feeder_pkg.sv
// Shared types and widths for the main-FIFO feeder.
// State encoding, default data width and counter widths.
package pcie_feeder_pkg;

  localparam int DATA_W_DEF  = 6;
  localparam int STATE_W     = 3;
  localparam int PUSH_CNT_W  = 8;
  localparam int PAUSE_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_PAUSED = 3'd4,
    S_ERROR  = 3'd5
  } state_e;

endpackage

// File: rtl/feeder_fifo.sv
// Skid buffer between the source and the main FIFO.
// Registered read side only: a written word is never visible same cycle.
module feeder_fifo
  import pcie_feeder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              rd_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("feeder_fifo: DEPTH must be a power of two >= 2");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       cnt_q;
  logic [AW:0]       cnt_d;
  logic              wr_ok;
  logic              rd_ok;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign wr_ok   = wr_i && !full_o;
  assign rd_ok   = rd_i && !empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Occupancy follows the net effect of this cycle's write and read.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers wrap naturally at DEPTH; flush empties without a reset.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage array is not reset; empty masks stale contents.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mf_feeder.sv
// Feeds buffered words into the main FIFO, honouring its pause.
// A pause held too long with data pending latches an error.
module mf_feeder
  import pcie_feeder_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int DEPTH         = 4,
  parameter int PAUSE_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  input  logic                  Pausa_MF,
  output logic                  push,
  output logic [DATA_W-1:0]     data_in_principal,
  output logic                  active_out,
  output logic                  idle_out,
  output logic                  error_out,
  output logic [PUSH_CNT_W-1:0] pushed_cnt
);

  localparam logic [PAUSE_CNT_W-1:0] PT =
    PAUSE_CNT_W'(PAUSE_TIMEOUT);

  state_e                  state_q;
  state_e                  state_d;
  logic [PAUSE_CNT_W-1:0]  pause_q;
  logic [PAUSE_CNT_W-1:0]  pause_d;
  logic [PAUSE_CNT_W-1:0]  pause_inc;
  logic [PUSH_CNT_W-1:0]   pcnt_q;
  logic [PUSH_CNT_W-1:0]   pcnt_d;
  logic                    active_q;
  logic                    idle_q;
  logic                    error_q;
  logic                    full;
  logic                    empty;
  logic                    wr_en;

  assign in_ready = !full &&
    (state_q inside {S_IDLE, S_ACTIVE, S_PAUSED});
  assign wr_en    = in_valid && in_ready;
  // init also blocks push so a flush never leaks a word.
  assign push     = (state_q == S_ACTIVE) && !empty &&
                    !Pausa_MF && !init;

  assign active_out = active_q;
  assign idle_out   = idle_q;
  assign error_out  = error_q;
  assign pushed_cnt = pcnt_q;

  feeder_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .flush_i (init),
    .wr_i    (wr_en),
    .wdata_i (in_data),
    .rd_i    (push),
    .rdata_o (data_in_principal),
    .full_o  (full),
    .empty_o (empty)
  );

  // Saturating pause count; only carried while staying in PAUSED.
  always_comb begin
    pause_inc = (pause_q == PT) ? PT : pause_q + 1'b1;
    pause_d   = '0;
    if (state_q == S_PAUSED && state_d == S_PAUSED)
      pause_d = pause_inc;
  end

  // Next-state decode; init overrides everything except RESET.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET:  state_d = S_INIT;
      S_INIT:   if (!init) state_d = S_IDLE;
      S_IDLE:   if (!empty) state_d = S_ACTIVE;
      S_ACTIVE: begin
        if (empty)         state_d = S_IDLE;
        else if (Pausa_MF) state_d = S_PAUSED;
      end
      S_PAUSED: begin
        if (!Pausa_MF)         state_d = S_ACTIVE;
        else if (pause_inc == PT) state_d = S_ERROR;
      end
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_RESET;
    endcase
    if (state_q != S_RESET && init) state_d = S_INIT;
  end

  // Push counter wraps at its width and clears in INIT.
  always_comb begin
    pcnt_d = pcnt_q;
    if (state_q == S_INIT) pcnt_d = '0;
    else if (push)         pcnt_d = pcnt_q + 1'b1;
  end

  // State, counters and registered flags advance together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RESET;
      pause_q  <= '0;
      pcnt_q   <= '0;
      active_q <= 1'b0;
      idle_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pause_q  <= pause_d;
      pcnt_q   <= pcnt_d;
      active_q <= (state_d == S_ACTIVE) ||
                  (state_d == S_PAUSED);
      idle_q   <= (state_d == S_IDLE);
      error_q  <= (state_d == S_ERROR);
    end
  end

endmodule

// File: tb/tb_mf_feeder.sv
// Scoreboard bench for mf_feeder.
// Driver queues accepted words; a negedge monitor checks every push.
module tb_mf_feeder;

  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          init = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          Pausa_MF = 1'b0;
  logic          in_ready;
  logic          push;
  logic [DW-1:0] data_in_principal;
  logic          active_out;
  logic          idle_out;
  logic          error_out;
  logic [7:0]    pushed_cnt;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] q [$];
  int            occ = 0;
  int            max_occ = 0;
  int            run = 0;
  int            max_run = 0;

  mf_feeder #(
    .DATA_W        (DW),
    .DEPTH         (4),
    .PAUSE_TIMEOUT (16)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .init              (init),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_ready          (in_ready),
    .Pausa_MF          (Pausa_MF),
    .push              (push),
    .data_in_principal (data_in_principal),
    .active_out        (active_out),
    .idle_out          (idle_out),
    .error_out         (error_out),
    .pushed_cnt        (pushed_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(d);
        done = 1;
      end
    end
    if (done) begin
      @(posedge clk);
      #1;
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: word %0h never accepted", d);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && q.size() != 0; t++) tick(1);
    chk("drain_left", q.size(), 0);
    tick(2);
  endtask

  // Every push must match the oldest accepted word.
  always @(negedge clk) begin
    logic [DW-1:0] exp;
    if (!reset) begin
      if (push) begin
        run++;
        if (run > max_run) max_run = run;
        chk("push_gate", int'(Pausa_MF | init), 0);
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL push_extra: got %0h expected none",
                   data_in_principal);
        end else begin
          exp = q.pop_front();
          chk("push_data", int'(data_in_principal), int'(exp));
        end
      end else begin
        run = 0;
      end
      if (init) occ = 0;
      else occ = occ + int'(in_valid && in_ready) - int'(push);
      if (occ > max_occ) max_occ = occ;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit hit;
    int pc;
    bit p;

    tick(3);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_push", push, 0);
    chk("rst_data", int'(data_in_principal), 0);
    chk("rst_active", active_out, 0);
    chk("rst_idle", idle_out, 0);
    chk("rst_error", error_out, 0);
    chk("rst_pcnt", int'(pushed_cnt), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(1);
    chk("init_in_ready", in_ready, 0);
    chk("init_idle", idle_out, 0);
    init = 1'b1;
    tick(2);
    init = 1'b0;
    tick(1);
    chk("idle_after_init", idle_out, 1);
    chk("ready_in_idle", in_ready, 1);

    max_run = 0;
    send(6'h15);
    send(6'h2A);
    send(6'h3F);
    drain();
    chk("burst_run", max_run, 3);
    chk("burst_pcnt", int'(pushed_cnt), 3);
    chk("burst_idle", idle_out, 1);

    Pausa_MF = 1'b1;
    send(6'h11);
    send(6'h22);
    send(6'h33);
    send(6'h04);
    in_valid = 1'b1;
    in_data  = 6'h35;
    repeat (3) begin
      @(negedge clk);
      chk("full_in_ready", in_ready, 0);
      chk("paused_push", push, 0);
    end
    @(posedge clk);
    #1;
    Pausa_MF = 1'b0;
    send(6'h35);
    drain();
    chk("pause_pcnt", int'(pushed_cnt), 8);

    Pausa_MF = 1'b1;
    send(6'h2C);
    n = 0;
    hit = 0;
    for (int t = 0; t < 40 && !hit; t++) begin
      @(negedge clk);
      if (error_out) hit = 1;
      else n += int'(active_out);
    end
    chk("err_reached", int'(hit), 1);
    chk("err_active_cycles", n, 17);
    chk("err_in_ready", in_ready, 0);
    chk("err_active", active_out, 0);
    @(posedge clk);
    #1;
    init = 1'b1;
    q.delete();
    Pausa_MF = 1'b0;
    tick(1);
    init = 1'b0;
    tick(1);
    chk("recover_idle", idle_out, 1);
    chk("recover_error", error_out, 0);
    chk("recover_pcnt", int'(pushed_cnt), 0);

    for (int i = 0; i < 300; i++) send(DW'(i));
    drain();
    chk("wrap_pcnt", int'(pushed_cnt), 44);

    Pausa_MF = 1'b1;
    send(6'h0A);
    send(6'h0B);
    send(6'h0C);
    init = 1'b1;
    q.delete();
    repeat (2) begin
      @(negedge clk);
      chk("init_no_push", push, 0);
    end
    @(posedge clk);
    #1;
    Pausa_MF = 1'b0;
    init = 1'b0;
    tick(1);
    chk("flush_idle", idle_out, 1);
    chk("flush_empty", int'(data_in_principal), 0);
    send(6'h01);
    drain();
    chk("flush_pcnt", int'(pushed_cnt), 1);

    pc = 0;
    max_occ = 0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      p = ($urandom_range(0, 9) < 4);
      if (pc >= 8) p = 0;
      pc = p ? pc + 1 : 0;
      Pausa_MF = p;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = DW'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) q.push_back(in_data);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    Pausa_MF = 1'b0;
    drain();
    n_cmp++;
    if (max_occ > 4) begin
      n_bad++;
      $display("FAIL max_occ: got %0d expected <= 4", max_occ);
    end
    chk("rand_error", error_out, 0);
    chk("rand_idle", idle_out, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
